// File: rtl/mod_bus_ctrl.sv
// mod_bus_ctrl: CPU-side memory bus controller in front of ROM, data RAM and IO.
// Decodes instruction and data addresses and drives registered slave enables.
// Sequences the 1-cycle synchronous ROM/RAM read and the variable-latency IO handshake.
// Returns data to the CPU with valid pulses and stalls the CPU via cpu_busy.
//
// Optional feature macro: BUS_CTRL_ERRADDR_EN adds err_addr[31:0], the last faulting address.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   cpu_ireq/cpu_iaddr            instruction fetch request and address
//   cpu_dreq/cpu_daddr/cpu_drw    data request, address, 1=write
//   cpu_din                       write data
//   cpu_busy                      access in flight
//   cpu_ivalid/cpu_iout           fetch-complete pulse and instruction
//   cpu_dvalid/cpu_dout           data-complete pulse and read data (0 on writes/faults)
//   bus_err                       fault pulse, coincident with the faulting valid
//   err_addr                      faulting address (BUS_CTRL_ERRADDR_EN only)
//   slv_iaddr/daddr/din/drw       combinational copies of the CPU request fields
//   rom_ie/rom_de/ram_ie/ram_de/io_de   registered slave enables
//   rom_iout/rom_dout/ram_iout/ram_dout/io_dout   slave read data
//   io_ready                      IO slave completes its access this cycle
module mod_bus_ctrl #(
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter int unsigned ROM_AW     = 11,
  parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
  parameter int unsigned RAM_AW     = 14,
  parameter logic [31:0] IO_BASE    = 32'hF000_0000,
  parameter int unsigned IO_AW      = 16,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ireq,
  input  logic [31:0] cpu_iaddr,
  input  logic        cpu_dreq,
  input  logic [31:0] cpu_daddr,
  input  logic        cpu_drw,
  input  logic [31:0] cpu_din,
  output logic        cpu_busy,
  output logic        cpu_ivalid,
  output logic [31:0] cpu_iout,
  output logic        cpu_dvalid,
  output logic [31:0] cpu_dout,
  output logic        bus_err,
`ifdef BUS_CTRL_ERRADDR_EN
  output logic [31:0] err_addr,
`endif
  output logic [31:0] slv_iaddr,
  output logic [31:0] slv_daddr,
  output logic [31:0] slv_din,
  output logic        slv_drw,
  output logic        rom_ie,
  output logic        rom_de,
  output logic        ram_ie,
  output logic        ram_de,
  output logic        io_de,
  input  logic [31:0] rom_iout,
  input  logic [31:0] rom_dout,
  input  logic [31:0] ram_iout,
  input  logic [31:0] ram_dout,
  input  logic [31:0] io_dout,
  input  logic        io_ready
);

  localparam int unsigned     CNT_W       = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IO_TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_IO_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ireq, r_dreq, r_drw;
  logic             w_ireq_nxt, w_dreq_nxt, w_drw_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_busy_nxt, w_ivalid_nxt, w_dvalid_nxt, w_err_nxt;
  logic [31:0]      w_iout_nxt, w_dout_nxt;
  logic             w_rom_ie_nxt, w_rom_de_nxt, w_ram_ie_nxt, w_ram_de_nxt, w_io_de_nxt;
  logic             w_i_rom_hit, w_i_ram_hit, w_d_rom_hit, w_d_ram_hit, w_d_io_hit;
  logic             w_i_flt, w_d_flt;

  // Slave-side request fields are straight copies
  assign slv_iaddr = cpu_iaddr;
  assign slv_daddr = cpu_daddr;
  assign slv_din   = cpu_din;
  assign slv_drw   = cpu_drw;

  // Region decode on the address bits above each region's size
  assign w_i_rom_hit = (cpu_iaddr >> ROM_AW) == (ROM_BASE >> ROM_AW);
  assign w_i_ram_hit = (cpu_iaddr >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign w_d_rom_hit = (cpu_daddr >> ROM_AW) == (ROM_BASE >> ROM_AW);
  assign w_d_ram_hit = (cpu_daddr >> RAM_AW) == (RAM_BASE >> RAM_AW);
  assign w_d_io_hit  = (cpu_daddr >> IO_AW)  == (IO_BASE  >> IO_AW);

  // In MEM the registered enables double as the latched decode: a request with no enable faulted
  assign w_i_flt   = r_ireq && !(rom_ie || ram_ie);
  assign w_d_flt   = r_dreq && !(rom_de || ram_de || io_de);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_ireq_nxt   = r_ireq;
    w_dreq_nxt   = r_dreq;
    w_drw_nxt    = r_drw;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = cpu_busy;
    w_ivalid_nxt = 1'b0;
    w_dvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_iout_nxt   = cpu_iout;
    w_dout_nxt   = cpu_dout;
    w_rom_ie_nxt = rom_ie;
    w_rom_de_nxt = rom_de;
    w_ram_ie_nxt = ram_ie;
    w_ram_de_nxt = ram_de;
    w_io_de_nxt  = io_de;
    unique case (r_state)
      ST_IDLE: begin
        if (cpu_ireq || cpu_dreq) begin
          w_ireq_nxt   = cpu_ireq;
          w_dreq_nxt   = cpu_dreq;
          w_drw_nxt    = cpu_drw;
          w_rom_ie_nxt = cpu_ireq && w_i_rom_hit;
          w_ram_ie_nxt = cpu_ireq && w_i_ram_hit;
          // ROM is read-only: a ROM write gets no enable and faults
          w_rom_de_nxt = cpu_dreq && w_d_rom_hit && !cpu_drw;
          w_ram_de_nxt = cpu_dreq && w_d_ram_hit;
          w_io_de_nxt  = cpu_dreq && w_d_io_hit;
          w_cnt_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = ST_MEM;
        end
      end
      ST_MEM: begin
        w_rom_ie_nxt = 1'b0;
        w_ram_ie_nxt = 1'b0;
        w_rom_de_nxt = 1'b0;
        w_ram_de_nxt = 1'b0;
        if (r_ireq) begin
          w_ivalid_nxt = 1'b1;
          w_iout_nxt   = rom_ie ? rom_iout : (ram_ie ? ram_iout : '0);
          w_err_nxt    = w_i_flt;
        end
        if (io_de) begin
          // Fetch completes now; data completion deferred to the IO handshake
          w_state_nxt = ST_IO_WAIT;
        end else begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
          if (r_dreq) begin
            w_dvalid_nxt = 1'b1;
            w_dout_nxt   = r_drw ? '0 : (rom_de ? rom_dout : (ram_de ? ram_dout : '0));
            w_err_nxt    = w_i_flt || w_d_flt;
          end
        end
      end
      ST_IO_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (io_ready) begin
          w_dvalid_nxt = 1'b1;
          w_dout_nxt   = r_drw ? '0 : io_dout;
          w_io_de_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else if (w_cnt_inc == TIMEOUT_CNT) begin
          w_dvalid_nxt = 1'b1;
          w_err_nxt    = 1'b1;
          w_dout_nxt   = '0;
          w_io_de_nxt  = 1'b0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ireq     <= 1'b0;
      r_dreq     <= 1'b0;
      r_drw      <= 1'b0;
      r_cnt      <= '0;
      cpu_busy   <= 1'b0;
      cpu_ivalid <= 1'b0;
      cpu_dvalid <= 1'b0;
      bus_err    <= 1'b0;
      cpu_iout   <= '0;
      cpu_dout   <= '0;
      rom_ie     <= 1'b0;
      rom_de     <= 1'b0;
      ram_ie     <= 1'b0;
      ram_de     <= 1'b0;
      io_de      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ireq     <= w_ireq_nxt;
      r_dreq     <= w_dreq_nxt;
      r_drw      <= w_drw_nxt;
      r_cnt      <= w_cnt_nxt;
      cpu_busy   <= w_busy_nxt;
      cpu_ivalid <= w_ivalid_nxt;
      cpu_dvalid <= w_dvalid_nxt;
      bus_err    <= w_err_nxt;
      cpu_iout   <= w_iout_nxt;
      cpu_dout   <= w_dout_nxt;
      rom_ie     <= w_rom_ie_nxt;
      rom_de     <= w_rom_de_nxt;
      ram_ie     <= w_ram_ie_nxt;
      ram_de     <= w_ram_de_nxt;
      io_de      <= w_io_de_nxt;
    end
  end

`ifdef BUS_CTRL_ERRADDR_EN
  logic [31:0] w_err_addr_nxt;

  // Data fault takes precedence; in IO_WAIT the only fault is a data timeout
  always_comb begin
    w_err_addr_nxt = err_addr;
    if (w_err_nxt) begin
      w_err_addr_nxt = ((r_state == ST_MEM) && !w_d_flt) ? cpu_iaddr : cpu_daddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_addr <= '0;
    end else begin
      err_addr <= w_err_addr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mod_bus_ctrl.sv
// Self-checking bench for mod_bus_ctrl: transaction-level model plus per-cycle compare.
module tb_mod_bus_ctrl;

  logic        clk, rst;
  logic        cpu_ireq, cpu_dreq, cpu_drw;
  logic [31:0] cpu_iaddr, cpu_daddr, cpu_din;
  logic        cpu_busy, cpu_ivalid, cpu_dvalid, bus_err;
  logic [31:0] cpu_iout, cpu_dout;
  logic [31:0] slv_iaddr, slv_daddr, slv_din;
  logic        slv_drw;
  logic        rom_ie, rom_de, ram_ie, ram_de, io_de;
  logic [31:0] rom_iout, rom_dout, ram_iout, ram_dout, io_dout;
  logic        io_ready;
`ifdef BUS_CTRL_ERRADDR_EN
  logic [31:0] err_addr;
`endif

  mod_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_ireq(cpu_ireq), .cpu_iaddr(cpu_iaddr),
    .cpu_dreq(cpu_dreq), .cpu_daddr(cpu_daddr), .cpu_drw(cpu_drw), .cpu_din(cpu_din),
    .cpu_busy(cpu_busy), .cpu_ivalid(cpu_ivalid), .cpu_iout(cpu_iout),
    .cpu_dvalid(cpu_dvalid), .cpu_dout(cpu_dout), .bus_err(bus_err),
`ifdef BUS_CTRL_ERRADDR_EN
    .err_addr(err_addr),
`endif
    .slv_iaddr(slv_iaddr), .slv_daddr(slv_daddr), .slv_din(slv_din), .slv_drw(slv_drw),
    .rom_ie(rom_ie), .rom_de(rom_de), .ram_ie(ram_ie), .ram_de(ram_de), .io_de(io_de),
    .rom_iout(rom_iout), .rom_dout(rom_dout), .ram_iout(ram_iout), .ram_dout(ram_dout),
    .io_dout(io_dout), .io_ready(io_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t0;
    int          abort;
    bit          ireq;
    bit          dreq;
    bit          drw;
    int          w;
    logic [31:0] iaddr, daddr, rom_i, ram_i, rom_d, ram_d, io_d;
  } txn_t;

  typedef struct packed {
    logic busy, ivalid, dvalid, bus_err, rom_ie, rom_de, ram_ie, ram_de, io_de;
  } ctl_t;

  typedef struct {
    string        name;
    logic [127:0] act;
    logic [127:0] exp;
  } lit_t;

  txn_t txns[32];
  int   n_txn = 0;
  lit_t lq[$];

  int n_chk = 0;
  int n_fail = 0;

  // Observations accumulated by the compare process, read by the stimulus
  int          last_iv_cyc = 0, last_dv_cyc = 0;
  logic [31:0] last_iout = '0, last_dout = '0;
  int          err_cnt = 0, io_de_cnt = 0, rom_de_cnt = 0, dv_cnt = 0;
  logic [31:0] exp_err_addr = '0;

  // 0 unmapped, 1 ROM, 2 RAM, 3 IO
  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_0800) return 1;
    if (a >= 32'h1000_0000 && a < 32'h1000_4000) return 2;
    if (a >= 32'hF000_0000 && a < 32'hF001_0000) return 3;
    return 0;
  endfunction

  // Number of IO_WAIT cycles the transaction spends (0 if the data target is not IO)
  function automatic int io_len(input txn_t t);
    if (!(t.dreq && region(t.daddr) == 3)) return 0;
    return (t.w > 255) ? 255 : t.w;
  endfunction

  // Expected registered outputs of one transaction at absolute cycle c
  function automatic void model(input txn_t t, input int c, output ctl_t o,
                                output logic [31:0] iout, output logic [31:0] dout,
                                output bit dflt);
    int  k, ir, dr, len;
    bit  alive, i_rom, i_ram, i_err, d_rom, d_ram, d_io, d_err, tmo;
    k     = c - t.t0;
    alive = (k >= 1) && (t.abort == 0 || c < t.abort);
    ir    = region(t.iaddr);
    dr    = region(t.daddr);
    i_rom = t.ireq && ir == 1;
    i_ram = t.ireq && ir == 2;
    i_err = t.ireq && !(i_rom || i_ram);
    d_rom = t.dreq && dr == 1 && !t.drw;
    d_ram = t.dreq && dr == 2;
    d_io  = t.dreq && dr == 3;
    d_err = t.dreq && !(d_rom || d_ram || d_io);
    tmo   = d_io && t.w > 255;
    len   = io_len(t);
    o     = '0;
    dflt  = 1'b0;
    if (alive) begin
      o.busy    = k <= 1 + len;
      o.rom_ie  = k == 1 && i_rom;
      o.ram_ie  = k == 1 && i_ram;
      o.rom_de  = k == 1 && d_rom;
      o.ram_de  = k == 1 && d_ram;
      o.io_de   = d_io && k <= 1 + len;
      o.ivalid  = t.ireq && k == 2;
      o.dvalid  = t.dreq && k == 2 + len;
      o.bus_err = (k == 2 && (i_err || d_err)) || (tmo && k == 2 + len);
      dflt      = (k == 2 && d_err) || (tmo && k == 2 + len);
    end
    iout = i_rom ? t.rom_i : (i_ram ? t.ram_i : 32'h0);
    dout = t.drw ? 32'h0 : (d_rom ? t.rom_d : (d_ram ? t.ram_d :
           ((d_io && !tmo) ? t.io_d : 32'h0)));
  endfunction

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Single compare process: model vs DUT every cycle, plus queued literal checks
  always @(negedge clk) begin
    ctl_t        e, p, a;
    logic [31:0] ei, ed, ti, td, ea;
    bit          df;
    lit_t        l;
    e  = '0;
    ei = '0;
    ed = '0;
    ea = exp_err_addr;
    for (int j = 0; j < n_txn; j++) begin
      model(txns[j], cyc, p, ti, td, df);
      if (p.ivalid) ei = ti;
      if (p.dvalid) ed = td;
      if (p.bus_err) ea = df ? txns[j].daddr : txns[j].iaddr;
      e = ctl_t'(e | p);
    end
    if (!rst) ea = '0;
    exp_err_addr = ea;
    a = {cpu_busy, cpu_ivalid, cpu_dvalid, bus_err, rom_ie, rom_de, ram_ie, ram_de, io_de};
    chk("ctl", 128'(a), 128'(e));
    if (e.ivalid) chk("iout", 128'(cpu_iout), 128'(ei));
    if (e.dvalid) chk("dout", 128'(cpu_dout), 128'(ed));
    if (!rst) begin
      chk("rst_iout", 128'(cpu_iout), 128'(0));
      chk("rst_dout", 128'(cpu_dout), 128'(0));
    end
    chk("slv", 128'({slv_iaddr, slv_daddr, slv_din, slv_drw}),
        128'({cpu_iaddr, cpu_daddr, cpu_din, cpu_drw}));
`ifdef BUS_CTRL_ERRADDR_EN
    chk("err_addr", 128'(err_addr), 128'(exp_err_addr));
`endif
    if (cpu_ivalid) begin last_iv_cyc = cyc; last_iout = cpu_iout; end
    if (cpu_dvalid) begin last_dv_cyc = cyc; last_dout = cpu_dout; dv_cnt++; end
    err_cnt    += int'(bus_err);
    io_de_cnt  += int'(io_de);
    rom_de_cnt += int'(rom_de);
    while (lq.size() > 0) begin
      l = lq.pop_front();
      chk(l.name, l.act, l.exp);
    end
  end

  task automatic lit(input string name, input logic [127:0] act, input logic [127:0] exp);
    lit_t l;
    l.name = name;
    l.act  = act;
    l.exp  = exp;
    lq.push_back(l);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the valid cycle so the next call is back-to-back
  task automatic run_txn(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                         input logic [31:0] daddr, input bit drw, input logic [31:0] din,
                         input int w, input int abort_k, output int t0);
    txn_t t;
    int   len;
    t.t0 = cyc;  t.abort = (abort_k > 0) ? cyc + abort_k : 0;
    t.ireq = ireq;  t.iaddr = iaddr;  t.dreq = dreq;  t.daddr = daddr;
    t.drw = drw;  t.w = w;
    t.rom_i = rom_iout;  t.ram_i = ram_iout;  t.rom_d = rom_dout;
    t.ram_d = ram_dout;  t.io_d = io_dout;
    txns[n_txn] = t;
    n_txn++;
    t0 = cyc;
    cpu_ireq = ireq;  cpu_iaddr = iaddr;  cpu_dreq = dreq;
    cpu_daddr = daddr;  cpu_drw = drw;  cpu_din = din;
    len = io_len(t);
    for (int k = 1; k <= 2 + len; k++) begin
      @(posedge clk);
      #1;
      io_ready = (len > 0) && (k == 1 + w);
      if (k == abort_k) begin
        #1;
        rst = 1'b0;
        cpu_ireq = 1'b0;  cpu_dreq = 1'b0;  io_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        break;
      end
    end
    cpu_ireq = 1'b0;
    cpu_dreq = 1'b0;
    io_ready = 1'b0;
  endtask

  initial begin
    int t0, s_err, s_io, s_rom, s_dv;
    rst = 1'b0;
    cpu_ireq = 1'b0;  cpu_dreq = 1'b0;  cpu_drw = 1'b0;
    cpu_iaddr = '0;  cpu_daddr = '0;  cpu_din = '0;
    rom_iout = '0;  rom_dout = '0;  ram_iout = '0;  ram_dout = '0;  io_dout = '0;
    io_ready = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(1);

    // Fetch from ROM
    rom_iout = 32'hDEAD_BEEF;
    s_err = err_cnt;
    run_txn(1, 32'h10, 0, 0, 0, 0, 0, 0, t0);
    idle(1);
    lit("t1_iout", 128'(last_iout), 128'(32'hDEAD_BEEF));
    lit("t1_lat", 128'(last_iv_cyc - t0), 128'(2));
    lit("t1_err", 128'(err_cnt - s_err), 128'(0));

    // Simultaneous ROM fetch and RAM read
    rom_iout = 32'hCAFE_0004;
    ram_dout = 32'h1234_5678;
    run_txn(1, 32'h4, 1, 32'h1000_0008, 0, 0, 0, 0, t0);
    idle(1);
    lit("t2_same", 128'(last_iv_cyc - last_dv_cyc), 128'(0));
    lit("t2_dout", 128'(last_dout), 128'(32'h1234_5678));
    lit("t2_iout", 128'(last_iout), 128'(32'hCAFE_0004));

    // IO read completing on the 3rd wait cycle
    io_dout = 32'h55;
    s_io = io_de_cnt;
    run_txn(0, 0, 1, 32'hF000_0004, 0, 0, 3, 0, t0);
    idle(1);
    lit("t3_dout", 128'(last_dout), 128'(32'h55));
    lit("t3_lat", 128'(last_dv_cyc - t0), 128'(5));
    lit("t3_iode", 128'(io_de_cnt - s_io), 128'(4));

    // IO read that never completes
    io_dout = 32'hFFFF_FFFF;
    s_io = io_de_cnt;
    s_err = err_cnt;
    run_txn(0, 0, 1, 32'hF000_0000, 0, 0, 1000, 0, t0);
    idle(1);
    lit("t4_iode", 128'(io_de_cnt - s_io), 128'(256));
    lit("t4_err", 128'(err_cnt - s_err), 128'(1));
    lit("t4_lat", 128'(last_dv_cyc - t0), 128'(257));
    lit("t4_dout", 128'(last_dout), 128'(0));

    // ROM write faults
    s_err = err_cnt;
    s_rom = rom_de_cnt;
    run_txn(0, 0, 1, 32'h20, 1, 32'hABCD, 0, 0, t0);
    idle(1);
    lit("t5_err", 128'(err_cnt - s_err), 128'(1));
    lit("t5_romde", 128'(rom_de_cnt - s_rom), 128'(0));
`ifdef BUS_CTRL_ERRADDR_EN
    lit("t5_eaddr", 128'(err_addr), 128'(32'h20));
`endif

    // Back-to-back chain: RAM fetch+write, unmapped fetch, ROM read, IO fetch + RAM top read
    s_err = err_cnt;
    ram_iout = 32'h7777_0100;
    run_txn(1, 32'h1000_0100, 1, 32'h1000_0200, 1, 32'h1111, 0, 0, t0);
    run_txn(1, 32'h2000_0000, 0, 0, 0, 0, 0, 0, t0);
    rom_dout = 32'h0B0B_0040;
    run_txn(0, 0, 1, 32'h40, 0, 0, 0, 0, t0);
    ram_dout = 32'h3FFC_3FFC;
    run_txn(1, 32'hF000_0010, 1, 32'h1000_3FFC, 0, 0, 0, 0, t0);
    idle(1);
    lit("t6_err", 128'(err_cnt - s_err), 128'(2));
    lit("t6_dout", 128'(last_dout), 128'(32'h3FFC_3FFC));
`ifdef BUS_CTRL_ERRADDR_EN
    lit("t6_eaddr", 128'(err_addr), 128'(32'hF000_0010));
`endif

    // ROM top fetch alongside an IO write
    rom_iout = 32'h7FC0_7FC0;
    run_txn(1, 32'h7FC, 1, 32'hF000_FFFC, 1, 32'h5A5A, 2, 0, t0);
    idle(1);
    lit("t7_dout", 128'(last_dout), 128'(0));
    lit("t7_order", 128'(last_dv_cyc - last_iv_cyc), 128'(2));

    // Region boundaries: just past ROM, just past RAM (data fault beats legal fetch)
    s_err = err_cnt;
    run_txn(0, 0, 1, 32'h800, 0, 0, 0, 0, t0);
    run_txn(1, 32'h0, 1, 32'h1000_4000, 0, 0, 0, 0, t0);
    idle(1);
    lit("t8_err", 128'(err_cnt - s_err), 128'(2));
`ifdef BUS_CTRL_ERRADDR_EN
    lit("t8_eaddr", 128'(err_addr), 128'(32'h1000_4000));
`endif

    // Reset during IO_WAIT abandons the access
    io_dout = 32'h99;
    s_dv = dv_cnt;
    run_txn(0, 0, 1, 32'hF000_0100, 0, 0, 1000, 5, t0);
    idle(4);
    lit("t9_nodv", 128'(dv_cnt - s_dv), 128'(0));
    lit("t9_busy", 128'(cpu_busy), 128'(0));

    // Normal operation after reset
    rom_iout = 32'h600D_0010;
    run_txn(1, 32'h10, 0, 0, 0, 0, 0, 0, t0);
    idle(2);
    lit("t10_iout", 128'(last_iout), 128'(32'h600D_0010));
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
